// File: rtl/icache_dm4.sv
// Direct-mapped 4-line instruction cache with 128-bit line fills.
// Keeps a saturating miss counter for bring-up.
module icache_dm4 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iready,
  output logic              ivalid,
  output logic [31:0]       idata,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_data,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned TAG_W = ADDR_W - 6;
  localparam int unsigned LINES = 4;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [LINE_W-1:0]  data_mem [LINES];

  logic [1:0]         word_q;
  logic [1:0]         idx_q;
  logic [TAG_W-1:0]   tag_q;

  logic [1:0]         req_word;
  logic [1:0]         req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [LINE_W-1:0]  hit_line;
  logic               hit;
  logic               unused_byte_bits;

  assign req_word         = iaddr[3:2];
  assign req_idx          = iaddr[5:4];
  assign req_tag          = iaddr[ADDR_W-1:6];
  assign unused_byte_bits = ^iaddr[1:0];

  // A flush in the lookup cycle forces a miss
  assign hit_line = data_mem[req_idx];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

  assign iready = (state == S_IDLE);

  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                           input logic [1:0]        w);
    sel_word = line[{w, 5'd0} +: 32];
  endfunction

  // Control FSM, valid bits and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      valid    <= '0;
      ivalid   <= 1'b0;
      idata    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      miss_cnt <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      tag_q    <= '0;
    end else begin
      ivalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ireq) begin
            word_q <= req_word;
            idx_q  <= req_idx;
            tag_q  <= req_tag;
            if (hit) begin
              ivalid <= 1'b1;
              idata  <= sel_word(hit_line, req_word);
            end else begin
              state    <= S_MISS;
              mem_req  <= 1'b1;
              mem_addr <= {req_tag, req_idx, 4'b0000};
              if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end
        end
        S_MISS: begin
          if (mem_ack) begin
            valid[idx_q] <= 1'b1;
            idata        <= sel_word(mem_data, word_q);
            ivalid       <= 1'b1;
            mem_req      <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Flush wins over a coincident fill's valid set
      if (flush) valid <= '0;
    end
  end

  // Line data and tag storage, written on fill completion
  always_ff @(posedge clk) begin
    if (rst && (state == S_MISS) && mem_ack) begin
      data_mem[idx_q] <= mem_data;
      tag_mem[idx_q]  <= tag_q;
    end
  end

endmodule
